// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// FSM encodings, requester count, default hold limit and a one-hot helper.
package mux4_rr_arbiter_pkg;

  localparam int NREQ         = 4;
  localparam int DEF_MAX_HOLD = 16;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT   = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit searching from ptr
// upward (mod 4); any flags whether a pick exists at all.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      pick,
  output logic            any
);

  // Walk the search order backwards so the lowest offset from ptr wins.
  always_comb begin
    pick = 2'b00;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: one grant at a time, bounded hold,
// and a one-cycle settle gap (RELEASE) between successive owners.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            rel,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            busy,
  output logic            timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [1:0] pick;
  logic       any;

  logic vol_exit;
  logic lim_exit;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // A voluntary exit (rel or owner dropping its request) always wins over the
  // hold limit, so timeout only flags grants that were actually revoked.
  always_comb begin
    vol_exit = rel | ~req[sel];
    lim_exit = (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= 2'b00;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= 2'b00;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            state    <= ST_GRANT;
            gnt      <= onehot4(pick);
            sel      <= pick;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (vol_exit || lim_exit) begin
            state   <= ST_RELEASE;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= lim_exit & ~vol_exit;
          end else begin
            // Exit at HOLD_LAST is forced, so the counter never wraps.
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
          ptr   <= sel + 2'd1;
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rel = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the mux, how long it has held it, whether the
  // settle cycle is in progress, and where the next search starts.
  int m_owner;
  int m_held;
  int m_ptr;
  int m_last;
  bit m_in_rel;
  bit m_to;

  logic [7:0] want;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {gnt, sel, busy, timeout};
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_held   = 0;
    m_ptr    = 0;
    m_last   = 0;
    m_in_rel = 1'b0;
    m_to     = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rl);
    bit vol;
    bit lim;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      vol = rl || !r[m_owner];
      lim = (m_held == MAX_HOLD);
      if (vol || lim) begin
        m_to     = lim && !vol;
        m_owner  = -1;
        m_in_rel = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_in_rel) begin
      m_in_rel = 1'b0;
      m_ptr    = (m_last + 1) % 4;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_last  = m_owner;
          m_held  = 1;
        end
      end
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, 2'(m_last), (m_owner >= 0), m_to};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(req, rel);
    #1;
  endtask

  task automatic go_idle();
    req = 4'b0000;
    rel = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    rel = 1'b0;
    model_reset();
    repeat (2) tick();
    total++;
    if (obs() !== 8'b0000_00_0_0) begin
      bad++; $display("FAIL reset_hold got=%b want=%b", obs(), 8'b0000_00_0_0);
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs() !== 8'b0000_00_0_0) begin
      bad++; $display("FAIL reset_idle got=%b want=%b", obs(), 8'b0000_00_0_0);
    end
  endtask

  task automatic test_single_grant();
    req = 4'b0100;
    tick();
    total++;
    if (obs() !== 8'b0100_10_1_0) begin
      bad++; $display("FAIL single_grant got=%b want=%b", obs(), 8'b0100_10_1_0);
    end
    rel = 1'b1;
    tick();
    total++;
    if (obs() !== 8'b0000_10_0_0) begin
      bad++; $display("FAIL single_release got=%b want=%b", obs(), 8'b0000_10_0_0);
    end
    rel = 1'b0;
    req = 4'b0000;
    tick();
    // Pointer should now be 3: with all requesting, 3 wins.
    req = 4'b1111;
    tick();
    total++;
    if (obs() !== 8'b1000_11_1_0) begin
      bad++; $display("FAIL ptr_after_release got=%b want=%b", obs(), 8'b1000_11_1_0);
    end
    go_idle();
  endtask

  task automatic test_round_robin();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        want = {4'(1 << (i % 4)), 2'(i % 4), 1'b1, 1'b0};
        total++;
        if (obs() !== want) begin
          bad++; $display("FAIL rr_grant owner=%0d cyc=%0d got=%b want=%b", i % 4, c, obs(), want);
        end
      end
      rel = 1'b1;
      for (int c = 0; c < 2; c++) begin
        tick();
        rel = 1'b0;
        want = {4'b0000, 2'(i % 4), 1'b0, 1'b0};
        total++;
        if (obs() !== want) begin
          bad++; $display("FAIL rr_gap owner=%0d cyc=%0d got=%b want=%b", i % 4, c, obs(), want);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_timeout();
    req = 4'b0001;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      total++;
      if (obs() !== 8'b0001_00_1_0) begin
        bad++; $display("FAIL to_hold cyc=%0d got=%b want=%b", c, obs(), 8'b0001_00_1_0);
      end
    end
    tick();
    total++;
    if (obs() !== 8'b0000_00_0_1) begin
      bad++; $display("FAIL to_pulse got=%b want=%b", obs(), 8'b0000_00_0_1);
    end
    tick();
    total++;
    if (obs() !== 8'b0000_00_0_0) begin
      bad++; $display("FAIL to_single_cycle got=%b want=%b", obs(), 8'b0000_00_0_0);
    end
    tick();
    total++;
    if (obs() !== 8'b0001_00_1_0) begin
      bad++; $display("FAIL to_regrant got=%b want=%b", obs(), 8'b0001_00_1_0);
    end
    req = 4'b0000;
    tick();
    total++;
    if (obs() !== 8'b0000_00_0_0) begin
      bad++; $display("FAIL to_drop_no_pulse got=%b want=%b", obs(), 8'b0000_00_0_0);
    end
    go_idle();
  endtask

  task automatic test_rel_at_limit();
    req = 4'b0010;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      total++;
      if (obs() !== 8'b0010_01_1_0) begin
        bad++; $display("FAIL lim_hold cyc=%0d got=%b want=%b", c, obs(), 8'b0010_01_1_0);
      end
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = 4'b0000;
    total++;
    if (obs() !== 8'b0000_01_0_0) begin
      bad++; $display("FAIL lim_rel_no_timeout got=%b want=%b", obs(), 8'b0000_01_0_0);
    end
    tick();
    total++;
    if (obs() !== 8'b0000_01_0_0) begin
      bad++; $display("FAIL lim_after got=%b want=%b", obs(), 8'b0000_01_0_0);
    end
    go_idle();
  endtask

  task automatic test_owner_drop();
    req = 4'b0101;
    tick();
    total++;
    if (obs() !== 8'b0100_10_1_0) begin
      bad++; $display("FAIL drop_grant2 got=%b want=%b", obs(), 8'b0100_10_1_0);
    end
    req = 4'b0111;
    tick();
    req = 4'b0101;
    total++;
    if (obs() !== 8'b0100_10_1_0) begin
      bad++; $display("FAIL drop_ignore_req1 got=%b want=%b", obs(), 8'b0100_10_1_0);
    end
    tick();
    req = 4'b0001;
    tick();
    total++;
    if (obs() !== 8'b0000_10_0_0) begin
      bad++; $display("FAIL drop_release got=%b want=%b", obs(), 8'b0000_10_0_0);
    end
    tick();
    tick();
    total++;
    if (obs() !== 8'b0001_00_1_0) begin
      bad++; $display("FAIL drop_wrap_to0 got=%b want=%b", obs(), 8'b0001_00_1_0);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    req = 4'b1000;
    tick();
    total++;
    if (obs() !== 8'b1000_11_1_0) begin
      bad++; $display("FAIL arst_pre got=%b want=%b", obs(), 8'b1000_11_1_0);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs() !== 8'b0000_00_0_0) begin
      bad++; $display("FAIL arst_immediate got=%b want=%b", obs(), 8'b0000_00_0_0);
    end
    req = 4'b1010;
    #1;
    rst = 1'b0;
    tick();
    total++;
    if (obs() !== 8'b0010_01_1_0) begin
      bad++; $display("FAIL arst_regrant got=%b want=%b", obs(), 8'b0010_01_1_0);
    end
    go_idle();
  endtask

  task automatic test_random();
    int to_seen;
    to_seen = 0;
    for (int i = 0; i < 700; i++) begin
      if (i < 350) begin
        if ($urandom_range(5) == 0) req = 4'($urandom);
        rel = ($urandom_range(9) == 0);
      end else begin
        if ($urandom_range(39) == 0) req = 4'($urandom);
        rel = 1'b0;
      end
      tick();
      want = model_vec();
      if (want[0]) to_seen++;
      total++;
      if (obs() !== want) begin
        bad++; $display("FAIL random cyc=%0d req=%b got=%b want=%b", i, req, obs(), want);
      end
    end
    $display("random run: timeouts expected=%0d", to_seen);
    go_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_rel_at_limit();
    test_owner_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
